// File: rtl/usb_control_cpu_pkg.sv
//------------------------------------------------------------------------------
// usb_control_cpu_pkg
//------------------------------------------------------------------------------
// Shared definitions for the sequential 32x32 -> 64 multiplier (mulx) used by
// the USB control CPU: FSM state encoding, default multiplier-cell latency and
// the partial-product shift amounts.
//
// Contents:
//   PP_LAT_DEFAULT  default cell latency (operand capture -> registered result)
//   mulx_state_e    sequencer states
//   pp_shift()      left shift applied to partial product k before accumulation
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package usb_control_cpu_pkg;

  localparam int PP_LAT_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIX   = 3'd3,
    ST_DONE  = 3'd4
  } mulx_state_e;

  // Partial products are issued as aL*bL, aL*bH, aH*bL, aH*bH.
  localparam logic [5:0] PP_SHIFT_LL = 6'd0;
  localparam logic [5:0] PP_SHIFT_MID = 6'd16;
  localparam logic [5:0] PP_SHIFT_HH = 6'd32;

  function automatic logic [5:0] pp_shift(input logic [1:0] k);
    case (k)
      2'd0:    return PP_SHIFT_LL;
      2'd1:    return PP_SHIFT_MID;
      2'd2:    return PP_SHIFT_MID;
      default: return PP_SHIFT_HH;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_control_cpu_mulx_fix.sv
//------------------------------------------------------------------------------
// usb_control_cpu_mulx_fix
//------------------------------------------------------------------------------
// Combinational signed-product correction of the upper product word.
// The multiplier cell always computes an unsigned product; for a signed
// operand with its MSB set the unsigned value is 2^32 too large, so the other
// operand (scaled by 2^32) is subtracted from the high word.
//
// Ports:
//   acc_hi_i       in  32  upper word of the unsigned 64-bit product
//   src1_i/src2_i  in  32  captured operands
//   src1_signed_i  in   1  treat src1 as two's complement
//   src2_signed_i  in   1  treat src2 as two's complement
//   hi_o           out 32  corrected upper word (modulo 2^32)
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module usb_control_cpu_mulx_fix (
  input  logic [31:0] acc_hi_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        src1_signed_i,
  input  logic        src2_signed_i,
  output logic [31:0] hi_o
);

  logic [31:0] corr1;
  logic [31:0] corr2;

  assign corr1 = (src1_signed_i && src1_i[31]) ? src2_i : 32'h0;
  assign corr2 = (src2_signed_i && src2_i[31]) ? src1_i : 32'h0;
  assign hi_o  = acc_hi_i - corr1 - corr2;

endmodule

`default_nettype wire

// File: rtl/usb_control_cpu_mulx_seq.sv
//------------------------------------------------------------------------------
// usb_control_cpu_mulx_seq
//------------------------------------------------------------------------------
// Sequencer for a 32x32 multiply built from four 16x16 unsigned partial
// products on an external pipelined multiplier cell. Partial products are
// issued one per cycle, accumulated into a 64-bit register as they emerge
// from the cell, sign-corrected, and the selected word is registered.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   start, flush             request pulse (IDLE only), synchronous abort
//   src1, src2               operands, captured on accept
//   src1_signed, src2_signed operand signedness, captured on accept
//   hi_sel                   1: product[63:32], 0: product[31:0]
//   busy, done, result       status, completion pulse, selected word
//   cell_src1, cell_src2     16-bit zero-extended operands to the cell
//   cell_signed, cell_en     cell mode (always unsigned), stage enable
//   cell_result              cell product, PP_LAT cycles after operands
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module usb_control_cpu_mulx_seq
  import usb_control_cpu_pkg::*;
#(
  parameter int PP_LAT = PP_LAT_DEFAULT  // must be >= 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        src1_signed,
  input  logic        src2_signed,
  input  logic        hi_sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_signed,
  output logic        cell_en,
  input  logic [31:0] cell_result
);

  // One counter spans ISSUE and DRAIN: value 0 is the first ISSUE cycle.
  localparam int              CNT_W         = $clog2(PP_LAT + 4) + 1;
  localparam logic [CNT_W-1:0] CNT_ISSUE_END = CNT_W'(3);
  localparam logic [CNT_W-1:0] CNT_DRAIN_END = CNT_W'(PP_LAT + 3);
  localparam logic [CNT_W-1:0] CNT_LAT       = CNT_W'(PP_LAT);
  localparam logic [1:0]       LAT_MOD4      = 2'(PP_LAT);

  mulx_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      result_q, result_d;
  logic [31:0]      a_q, b_q;
  logic             a_sgn_q, b_sgn_q, hi_sel_q;

  logic             accept;
  logic             in_pipe;
  logic [1:0]       k_ret;
  logic [31:0]      fix_hi;

  assign accept  = (state_q == ST_IDLE) && start && !flush;
  assign in_pipe = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  // Index of the partial product currently leaving the cell.
  assign k_ret   = cnt_q[1:0] - LAT_MOD4;

  usb_control_cpu_mulx_fix u_fix (
    .acc_hi_i      (acc_q[63:32]),
    .src1_i        (a_q),
    .src2_i        (b_q),
    .src1_signed_i (a_sgn_q),
    .src2_signed_i (b_sgn_q),
    .hi_o          (fix_hi)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      a_sgn_q  <= 1'b0;
      b_sgn_q  <= 1'b0;
      hi_sel_q <= 1'b0;
    end else if (accept) begin
      a_q      <= src1;
      b_q      <= src2;
      a_sgn_q  <= src1_signed;
      b_sgn_q  <= src2_signed;
      hi_sel_q <= hi_sel;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;

    // Partial product k emerges when cnt == k + PP_LAT, in ISSUE or DRAIN.
    if (in_pipe && (cnt_q >= CNT_LAT)) begin
      acc_d = acc_q + ({32'h0, cell_result} << pp_shift(k_ret));
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_ISSUE_END) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_DRAIN_END) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = hi_sel_q ? fix_hi : acc_q[31:0];
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort leaves accumulator and result untouched.
    if (flush) begin
      state_d  = ST_IDLE;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      result_d = result_q;
    end
  end

  always_comb begin
    cell_src1 = '0;
    cell_src2 = '0;
    if (state_q == ST_ISSUE) begin
      // cnt bit1 picks the src1 half, bit0 the src2 half.
      cell_src1 = {16'h0, cnt_q[1] ? a_q[31:16] : a_q[15:0]};
      cell_src2 = {16'h0, cnt_q[0] ? b_q[31:16] : b_q[15:0]};
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign cell_en     = in_pipe;
  assign cell_signed = 1'b0;
  assign result      = result_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_control_cpu_mulx_seq.sv
//------------------------------------------------------------------------------
// tb_usb_control_cpu_mulx_seq
//------------------------------------------------------------------------------
// Self-checking bench: a behavioural multiplier cell feeds the DUT, and
// results are compared against a 64-bit arithmetic product model.
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_usb_control_cpu_mulx_seq;

  localparam int PP_LAT   = 2;
  localparam int DONE_LAT = 6 + PP_LAT;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        flush;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        src1_signed;
  logic        src2_signed;
  logic        hi_sel;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic        cell_signed;
  logic        cell_en;
  logic [31:0] cell_result;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_last = 32'h0;

  usb_control_cpu_mulx_seq #(.PP_LAT(PP_LAT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .flush       (flush),
    .src1        (src1),
    .src2        (src2),
    .src1_signed (src1_signed),
    .src2_signed (src2_signed),
    .hi_sel      (hi_sel),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .cell_src1   (cell_src1),
    .cell_src2   (cell_src2),
    .cell_signed (cell_signed),
    .cell_en     (cell_en),
    .cell_result (cell_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier cell: PP_LAT enabled register stages.
  logic [31:0] cpipe [PP_LAT];
  always @(posedge clk) begin
    if (cell_en) begin
      cpipe[0] <= cell_src1 * cell_src2;
      for (int i = 1; i < PP_LAT; i++) cpipe[i] <= cpipe[i-1];
    end
  end
  assign cell_result = cpipe[PP_LAT-1];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s1, input logic s2, input logic hs);
    logic [63:0] ea, eb, p;
    ea = s1 ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s2 ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return hs ? p[63:32] : p[31:0];
  endfunction

  // Drives one operation from IDLE and waits for done; returns the result,
  // the cycle of done relative to accept, and a count of protocol deviations.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s1,
                        input logic s2, input logic hs, output logic [31:0] got,
                        output int lat, output int shape_err);
    shape_err = 0;
    lat       = -1;
    got       = 32'h0;
    @(negedge clk);
    src1 = a; src2 = b; src1_signed = s1; src2_signed = s2; hi_sel = hs;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b1) shape_err++;
      if (cell_en !== ((c <= 4 + PP_LAT) ? 1'b1 : 1'b0)) shape_err++;
      if (c > 4 && (cell_src1 !== 32'h0 || cell_src2 !== 32'h0)) shape_err++;
      if (cell_signed !== 1'b0) shape_err++;
      if (done === 1'b1) begin
        lat = c;
        got = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; flush = 1'b0;
    src1 = 32'h0; src2 = 32'h0; src1_signed = 1'b0; src2_signed = 1'b0; hi_sel = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (cell_en !== 1'b0) begin bad++; $display("FAIL reset_cell_en: got %b want 0", cell_en); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
    total++; if (cell_src1 !== 32'h0 || cell_src2 !== 32'h0) begin
      bad++; $display("FAIL reset_cell_src: got %h/%h want 0/0", cell_src1, cell_src2);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] ta [10];
    logic [31:0] tb [10];
    logic [2:0]  tf [10];  // {s1, s2, hi_sel}
    logic [31:0] te [10];
    logic [31:0] got;
    int lat, se;
    ta = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'h00010000, 32'h00000000};
    tb = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'h00000002,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'h00010000, 32'h12345678};
    tf = '{3'b001, 3'b000, 3'b111, 3'b111, 3'b110, 3'b101, 3'b100, 3'b001, 3'b000, 3'b111};
    te = '{32'hFFFFFFFE, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h00000000,
           32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 10; i++) begin
      run_op(ta[i], tb[i], tf[i][2], tf[i][1], tf[i][0], got, lat, se);
      exp_last = te[i];
      total++; if (got !== te[i]) begin
        bad++; $display("FAIL directed_%0d_result: got %h want %h", i, got, te[i]);
      end
      total++; if (lat !== DONE_LAT) begin
        bad++; $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, DONE_LAT);
      end
      total++; if (se !== 0) begin
        bad++; $display("FAIL directed_%0d_protocol: got %0d deviations want 0", i, se);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] corners [4];
    logic [31:0] a, b, got, exp;
    logic s1, s2, hs;
    int lat, se;
    corners = '{32'h00000000, 32'h00000001, 32'h80000000, 32'hFFFFFFFF};
    for (int i = 0; i < 40; i++) begin
      a  = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      s1 = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      hs = 1'($urandom_range(0, 1));
      exp = ref_mul(a, b, s1, s2, hs);
      run_op(a, b, s1, s2, hs, got, lat, se);
      exp_last = exp;
      total++; if (got !== exp) begin
        bad++; $display("FAIL random_%0d_result: a=%h b=%h s=%b%b hi=%b got %h want %h",
                        i, a, b, s1, s2, hs, got, exp);
      end
      total++; if (lat !== DONE_LAT || se !== 0) begin
        bad++; $display("FAIL random_%0d_timing: got lat %0d dev %0d want lat %0d dev 0",
                        i, lat, se, DONE_LAT);
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone, done_at;
    logic [31:0] got;
    @(negedge clk);
    src1 = 32'h00010000; src2 = 32'h00010000; src1_signed = 1'b0; src2_signed = 1'b0;
    hi_sel = 1'b1; start = 1'b1;
    ndone = 0; done_at = -1; got = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 3) begin
        src1 = 32'h5; src2 = 32'h7; hi_sel = 1'b0; start = 1'b1;
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_at < 0) begin done_at = c; got = result; end
        start = 1'b1;  // start coincident with done must also be ignored
      end
    end
    start = 1'b0;
    exp_last = 32'h00000001;
    total++; if (ndone !== 1) begin bad++; $display("FAIL ignore_start_done_count: got %0d want 1", ndone); end
    total++; if (done_at !== DONE_LAT) begin
      bad++; $display("FAIL ignore_start_latency: got %0d want %0d", done_at, DONE_LAT);
    end
    total++; if (got !== 32'h00000001) begin bad++; $display("FAIL ignore_start_result: got %h want 00000001", got); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_start_idle: got busy %b want 0", busy); end
    total++; if (result !== 32'h00000001) begin bad++; $display("FAIL ignore_start_hold: got %h want 00000001", result); end
  endtask

  task automatic test_flush();
    int ndone;
    logic busy_after;
    @(negedge clk);
    src1 = $urandom; src2 = $urandom; src1_signed = 1'b1; src2_signed = 1'b0; hi_sel = 1'b1;
    start = 1'b1;
    busy_after = 1'bx;
    ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) begin busy_after = busy; flush = 1'b0; end
      if (c == 4) flush = 1'b1;
      if (done === 1'b1) ndone++;
    end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy_after); end
    total++; if (ndone !== 0) begin bad++; $display("FAIL flush_no_done: got %0d dones want 0", ndone); end
    total++; if (result !== exp_last) begin bad++; $display("FAIL flush_result_kept: got %h want %h", result, exp_last); end
    // flush together with start in IDLE: flush wins
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_beats_start: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    logic [4:0] snap;
    logic [31:0] rsnap;
    @(negedge clk);
    src1 = 32'hDEADBEEF; src2 = 32'h12345678; src1_signed = 1'b0; src2_signed = 1'b0; hi_sel = 1'b0;
    start = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) ndone++;
    end
    reset_n = 1'b0;
    #1;
    snap  = {busy, done, cell_en, |cell_src1, |cell_src2};
    rsnap = result;
    total++; if (snap !== 5'b0) begin bad++; $display("FAIL reset_mid_outputs: got %b want 00000", snap); end
    total++; if (rsnap !== 32'h0) begin bad++; $display("FAIL reset_mid_result: got %h want 0", rsnap); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL reset_mid_no_done: got %0d dones want 0", ndone); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, got;
    int lat, se;
    // After a reset the first op still finishes with the correct product.
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      run_op(a, b, 1'b1, 1'b1, i[0], got, lat, se);
      total++; if (got !== ref_mul(a, b, 1'b1, 1'b1, i[0]) || lat !== DONE_LAT) begin
        bad++; $display("FAIL back_to_back_%0d: got %h lat %0d want %h lat %0d",
                        i, got, lat, ref_mul(a, b, 1'b1, 1'b1, i[0]), DONE_LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/usb_control_cpu_mulx_seq.md
USB_CONTROL_CPU_MULX_SEQ -- requirements
Module: usb_control_cpu_mulx_seq

Interface
REQ-001 SHALL have parameter PP_LAT, default 2, giving the multiplier-cell latency in cycles from operand capture to registered result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 flush  input  1  synchronous abort; back to IDLE, no done.
REQ-006 src1, src2  input  32 each  operands; captured on accepted start.
REQ-007 src1_signed, src2_signed  input  1 each  operand signedness; captured with operands.
REQ-008 hi_sel  input  1  1 returns product[63:32], 0 returns product[31:0]; captured with operands.
REQ-009 busy  output  1  high from cycle after accept until done cycle inclusive.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 result  output  32  selected product word; valid while done=1, held until next accept.
REQ-012 cell_src1, cell_src2  output  32 each  partial-product operands to the multiplier cell.
REQ-013 cell_signed  output  1  tied 0; cell always runs unsigned.
REQ-014 cell_en  output  1  drives both cell stage enables.
REQ-015 cell_result  input  32  registered cell product, PP_LAT cycles after operands driven.

Function
REQ-016 States: IDLE, ISSUE, DRAIN, FIX, DONE.
REQ-017 IDLE: start=1 captures operands, clears 64-bit accumulator and issue counter, moves to ISSUE.
REQ-018 ISSUE: four cycles, counter k=0..3, driving {zero-extended 16-bit halves} k0 aL*bL, k1 aL*bH, k2 aH*bL, k3 aH*bH; then DRAIN.
REQ-019 Result for partial product k SHALL be added to accumulator in cycle 1+k+PP_LAT (cycle 1 = first ISSUE cycle), shifted left 0, 16, 16, 32 bits for k=0..3.
REQ-020 DRAIN: lasts PP_LAT cycles, completing accumulation of k=3; then FIX.
REQ-021 FIX: hi = acc[63:32] - (src1_signed & a[31] ? b : 0) - (src2_signed & b[31] ? a : 0), modulo 2^32; lo = acc[31:0]; registers result per hi_sel; then DONE.
REQ-022 DONE: done=1 one cycle, then IDLE; total done = cycle 8 after accept with PP_LAT=2.
REQ-023 cell_en SHALL be 1 in ISSUE and DRAIN, 0 otherwise; cell_src1/cell_src2 SHALL be 0 outside ISSUE.
REQ-024 start outside IDLE SHALL be ignored; start coincident with done (DONE state) ignored.
REQ-025 flush in any state SHALL force IDLE next cycle, busy=0, done never asserted for the aborted op, result unchanged; flush wins over start.
REQ-026 Accumulator SHALL be 64 bits; carries beyond bit 63 discarded.

Reset
REQ-027 On reset_n=0: state IDLE, busy=0, done=0, cell_en=0, result=0, accumulator=0, counter=0, cell_src1/cell_src2=0, immediately and asynchronously.
REQ-028 Reset mid-operation SHALL abandon the op; no done after reset release.

Structure
REQ-029 State encoding, PP_LAT default and shift amounts SHALL live in shared package usb_control_cpu_pkg.
REQ-030 Sign correction (REQ-021) SHALL be sub-module usb_control_cpu_mulx_fix, combinational, 32-bit in/out.

Verification
REQ-031 unsigned 0xFFFFFFFF x 0xFFFFFFFF, hi_sel=1 -> result 0xFFFFFFFE at done, 8 cycles after accept; hi_sel=0 -> 0x00000001.
REQ-032 signed x signed 0xFFFFFFFF x 0xFFFFFFFF, hi_sel=1 -> 0x00000000; signed 0x80000000 x 0x00000002 -> hi 0xFFFFFFFF, lo 0x00000000.
REQ-033 src1 signed, src2 unsigned, 0xFFFFFFFF x 0xFFFFFFFF -> hi 0xFFFFFFFF, lo 0x00000001.
REQ-034 unsigned 0x00010000 x 0x00010000 -> hi 0x00000001, lo 0x00000000; second start during busy ignored, only one done.
REQ-035 flush in cycle 4 after accept -> busy=0 next cycle, no done, result keeps previous value; reset_n low in cycle 5 -> all outputs 0, no done.
